// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART transmitter.
// Optional HOLD idle timeout is compiled in with `define UART_TX_ARB_TIMEOUT_EN.

module uart_tx_arbiter_chk #(
  parameter int NumReq        = 4,
  parameter int TimeoutCycles = 65535
) (
  input logic              clk,
  input logic              nReset,
  input logic              tx_valid,
  input logic              tx_done,
  input logic              inWait,
  input logic [NumReq-1:0] req_valid,
  input logic [NumReq-1:0] req_ready
);
  logic armed;

  // A byte launched before a reset may still complete after it, so tx_done is policed only once this run has sent one.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      armed <= 1'b0;
    end else if (tx_valid) begin
      armed <= 1'b1;
    end else begin
      armed <= armed;
    end
  end

  strayDone: assert property (@(posedge clk) disable iff (!nReset) (tx_done && armed) |-> inWait)
    else $error("tx_done received outside WAIT");

  readyRule: assert property (@(posedge clk) disable iff (!nReset)
    (((req_ready & ~req_valid) == '0) && $onehot0(req_ready)));

  paramRange: assert property (@(posedge clk)
    (NumReq >= 1) && (NumReq <= 16) && (TimeoutCycles >= 1) && (TimeoutCycles <= 65535));
endmodule

module uart_tx_arbiter #(
  parameter int NumReq        = 4,
  parameter int IdxW          = (NumReq > 1) ? $clog2(NumReq) : 1,
  parameter int TimeoutCycles = 65535
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic [NumReq-1:0]   req_valid,
  input  logic [8*NumReq-1:0] req_data,
  input  logic [NumReq-1:0]   req_last,
  output logic [NumReq-1:0]   req_ready,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_done,
  output logic [IdxW-1:0]     grant,
  output logic                busy
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic                timeout
`endif
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t          state;
  state_t          nextState;
  logic [IdxW-1:0] rr;
  logic [IdxW-1:0] nextRr;
  logic            lastQ;
  logic            accept;
  logic [IdxW-1:0] selIdx;
  logic            scanHit;
  logic [IdxW-1:0] scanIdx;
  logic [IdxW-1:0] cand;
  logic [7:0]      reqByte [NumReq];

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [15:0] HoldLimit = 16'(TimeoutCycles - 1);
  logic [15:0] holdCnt;
  logic        dropLock;
`endif

  // Unpack the requester byte lanes.
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      reqByte[i] = req_data[8*i +: 8];
    end
  end

  // Round-robin scan starting just after the most recent packet owner.
  always_comb begin
    scanHit = 1'b0;
    scanIdx = rr;
    cand    = '0;
    for (int k = 1; k <= NumReq; k++) begin
      cand = IdxW'((int'(rr) + k) % NumReq);
      if (!scanHit && req_valid[cand]) begin
        scanHit = 1'b1;
        scanIdx = cand;
      end else begin
        scanHit = scanHit;
      end
    end
  end

  // Next-state, pointer update and acceptance decision.
  always_comb begin
    nextState = state;
    nextRr    = rr;
    accept    = 1'b0;
    selIdx    = grant;
`ifdef UART_TX_ARB_TIMEOUT_EN
    dropLock  = 1'b0;
`endif
    case (state)
      IDLE: begin
        // Nothing is accepted while reset is held, so no byte is lost to it.
        if (scanHit && nReset) begin
          accept    = 1'b1;
          selIdx    = scanIdx;
          nextState = SEND;
        end else begin
          nextState = IDLE;
        end
      end
      SEND: begin
        nextState = WAIT;
      end
      WAIT: begin
        if (tx_done && lastQ) begin
          nextRr    = grant;
          nextState = IDLE;
        end else if (tx_done) begin
          nextState = HOLD;
        end else begin
          nextState = WAIT;
        end
      end
      HOLD: begin
        if (req_valid[grant] && nReset) begin
          accept    = 1'b1;
          selIdx    = grant;
          nextState = SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
        end else if (holdCnt == HoldLimit) begin
          dropLock  = 1'b1;
          nextRr    = grant;
          nextState = IDLE;
`endif
        end else begin
          nextState = HOLD;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // One-hot ready toward the accepted requester.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[selIdx] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // State, pointer and registered transmitter-side outputs.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      rr       <= IdxW'(NumReq - 1);
      lastQ    <= 1'b0;
      tx_data  <= 8'h00;
      grant    <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= nextState;
      rr       <= nextRr;
      tx_valid <= (nextState == SEND);
      busy     <= (nextState != IDLE);
      if (accept) begin
        tx_data <= reqByte[selIdx];
        lastQ   <= req_last[selIdx];
        grant   <= selIdx;
      end else begin
        tx_data <= tx_data;
        lastQ   <= lastQ;
        grant   <= grant;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  // Idle cycles spent in HOLD; held at zero elsewhere so every entry starts fresh.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      holdCnt <= 16'd0;
      timeout <= 1'b0;
    end else begin
      timeout <= dropLock;
      if (state == HOLD && !accept && !dropLock) begin
        holdCnt <= holdCnt + 16'd1;
      end else begin
        holdCnt <= 16'd0;
      end
    end
  end
`endif

  uart_tx_arbiter_chk #(
    .NumReq        (NumReq),
    .TimeoutCycles (TimeoutCycles)
  ) uChk (
    .clk       (clk),
    .nReset    (nReset),
    .tx_valid  (tx_valid),
    .tx_done   (tx_done),
    .inWait    (state == WAIT),
    .req_valid (req_valid),
    .req_ready (req_ready)
  );
endmodule
